// File: rtl/led_breath_scheduler.sv
// led_breath_scheduler: breathing chaser that time-shares one PWM/duty-table engine across NUM_CH LEDs.
// Define LED_BREATH_ALL_EN to add the all_sw input, which drives every LED together and skips the dark gap.
module led_breath_scheduler #(
   parameter int NUM_CH = 8,
   parameter int PWM_BITS = 6,
   parameter int GAP_PERIODS = 4,
   localparam int CW = $clog2(NUM_CH)
) (
   input  logic                sysclk,
   input  logic                reset,
   input  logic                enable_sw,
   input  logic                dir_sw,
`ifdef LED_BREATH_ALL_EN
   input  logic                all_sw,
`endif
   output logic [PWM_BITS-1:0] lut_index,
   input  logic [PWM_BITS-1:0] lut_duty,
   output logic [NUM_CH-1:0]   pulse,
   output logic [CW-1:0]       active_ch,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
   state_t state_q, state_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, lut_index_q, lut_index_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;
   logic [CW-1:0] active_ch_q, active_ch_d, next_ch;
   logic [NUM_CH-1:0] pulse_q, pulse_d;
   logic busy_q, busy_d, all_mode_q, all_mode_d;
   logic [1:0] en_sync_q, dir_sync_q;
   logic en_s, dir_s, all_s, eop, pwm_bit;
   assign en_s = en_sync_q[1];
   assign dir_s = dir_sync_q[1];
`ifdef LED_BREATH_ALL_EN
   logic [1:0] all_sync_q;
   assign all_s = all_sync_q[1];
   always_ff @(posedge sysclk or posedge reset)
      if (reset) all_sync_q <= '0;
      else all_sync_q <= {all_sync_q[0], all_sw};
`else
   assign all_s = 1'b0;
`endif
   assign eop = &pwm_cnt_q;
   assign pwm_bit = pwm_cnt_q < lut_duty;
   assign next_ch = dir_s ? ((active_ch_q == '0) ? CW'(NUM_CH - 1) : active_ch_q - 1'b1)
                          : ((active_ch_q == CW'(NUM_CH - 1)) ? '0 : active_ch_q + 1'b1);
   always_comb begin
      state_d = state_q;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      lut_index_d = lut_index_q;
      gap_cnt_d = gap_cnt_q;
      active_ch_d = active_ch_q;
      all_mode_d = all_mode_q;
      pulse_d = '0;
      if (state_q == RUN && en_s)
         pulse_d = all_mode_q ? {NUM_CH{pwm_bit}} : NUM_CH'(pwm_bit) << active_ch_q;
      if (!en_s) begin
         state_d = IDLE;
         pwm_cnt_d = '0;
         lut_index_d = '0;
         gap_cnt_d = '0;
      end else if (state_q == IDLE) begin
         state_d = RUN;
         pwm_cnt_d = '0;
         all_mode_d = all_s;
      end else if (state_q == RUN) begin
         // lut_index wraps to 0 by itself on the final step of the dwell
         if (eop) lut_index_d = lut_index_q + 1'b1;
         if (eop && &lut_index_q) begin
            state_d = all_s ? RUN : GAP;
            active_ch_d = all_s ? next_ch : active_ch_q;
            gap_cnt_d = '0;
            all_mode_d = all_s;
         end
      end else begin
         if (eop) gap_cnt_d = gap_cnt_q + 1'b1;
         if (eop && gap_cnt_q == 8'(GAP_PERIODS - 1)) begin
            state_d = RUN;
            active_ch_d = next_ch;
            all_mode_d = all_s;
         end
      end
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge sysclk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         pwm_cnt_q <= '0;
         lut_index_q <= '0;
         gap_cnt_q <= '0;
         active_ch_q <= '0;
         pulse_q <= '0;
         busy_q <= 1'b0;
         all_mode_q <= 1'b0;
         en_sync_q <= '0;
         dir_sync_q <= '0;
      end else begin
         state_q <= state_d;
         pwm_cnt_q <= pwm_cnt_d;
         lut_index_q <= lut_index_d;
         gap_cnt_q <= gap_cnt_d;
         active_ch_q <= active_ch_d;
         pulse_q <= pulse_d;
         busy_q <= busy_d;
         all_mode_q <= all_mode_d;
         en_sync_q <= {en_sync_q[0], enable_sw};
         dir_sync_q <= {dir_sync_q[0], dir_sw};
      end
   assign lut_index = lut_index_q;
   assign pulse = pulse_q;
   assign active_ch = active_ch_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_led_breath_scheduler.sv
// tb_led_breath_scheduler: directed bench for led_breath_scheduler with a sine (or constant) duty lookup model.
module tb_led_breath_scheduler;
   logic sysclk = 1'b0, reset = 1'b1, enable_sw = 1'b0, dir_sw = 1'b0, const_mode = 1'b0;
   logic [5:0] lut_index, lut_duty;
   logic [7:0] pulse;
   logic [2:0] active_ch;
   logic busy;
   logic [5:0] sine [64];
   int checks = 0, passes = 0;
`ifdef LED_BREATH_ALL_EN
   logic all_sw = 1'b0;
`endif
   led_breath_scheduler dut (
      .sysclk(sysclk), .reset(reset), .enable_sw(enable_sw), .dir_sw(dir_sw),
`ifdef LED_BREATH_ALL_EN
      .all_sw(all_sw),
`endif
      .lut_index(lut_index), .lut_duty(lut_duty), .pulse(pulse), .active_ch(active_ch), .busy(busy));
   always #5 sysclk = ~sysclk;
   always_comb lut_duty = const_mode ? 6'd16 : sine[lut_index];
   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation did not finish (passed %0d of %0d)", passes, checks);
      $fatal(1);
   end
   function automatic int duty(input int k);
      return const_mode ? 16 : int'(sine[k]);
   endfunction
   task automatic test_reset;
      reset = 1'b1; enable_sw = 1'b1; dir_sw = 1'b0;
      repeat (10) @(negedge sysclk);
      checks++; if (pulse !== 8'h00) $display("FAIL reset_pulse: got %h want 00", pulse); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
      checks++; if (active_ch !== 3'd0) $display("FAIL reset_ch: got %0d want 0", active_ch); else passes++;
      checks++; if (lut_index !== 6'd0) $display("FAIL reset_index: got %0d want 0", lut_index); else passes++;
      reset = 1'b0;
      repeat (2) @(negedge sysclk);
      checks++; if (busy !== 1'b0) $display("FAIL sync_latency: busy %b after 2 clocks want 0", busy); else passes++;
      @(negedge sysclk);
      checks++; if (busy !== 1'b1) $display("FAIL start_busy: busy %b after 3 clocks want 1", busy); else passes++;
   endtask
   // Starts at the negedge just after RUN began on ch (pwm_cnt = 0); ends at the same point of the next dwell.
   task automatic run_dwell(input int ch, input int nxt, input int dir_at, input logic dir_val);
      int bad, first_bad, highs, period_highs, exp_idx;
      logic [7:0] exp_p;
      bad = 0; first_bad = -1; highs = 0; period_highs = 0;
      for (int j = 0; j < 4352; j++) begin
         exp_p = '0;
         if (j >= 1 && j <= 4096) exp_p[ch] = ((j - 1) % 64) < duty((j - 1) / 64);
         exp_idx = (j < 4096) ? j / 64 : 0;
         if (pulse !== exp_p || int'(lut_index) !== exp_idx || int'(active_ch) !== ch || busy !== 1'b1) begin
            if (bad == 0) first_bad = j;
            bad++;
         end
         if (pulse[ch]) highs++;
         if (j >= 1 && j <= 64 && pulse[ch]) period_highs++;
         if (j == dir_at) dir_sw = dir_val;
         @(negedge sysclk);
      end
      checks++;
      if (bad != 0) $display("FAIL dwell_ch%0d: %0d bad cycles (first at %0d) want 0", ch, bad, first_bad); else passes++;
      checks++;
      if (int'(active_ch) !== nxt) $display("FAIL advance_from_%0d: got %0d want %0d", ch, active_ch, nxt); else passes++;
      checks++;
      if (highs == 0) $display("FAIL activity_ch%0d: pulse never high", ch); else passes++;
      if (const_mode) begin
         checks++;
         if (period_highs != 16) $display("FAIL const_period_ch%0d: %0d high clocks want 16", ch, period_highs); else passes++;
         checks++;
         if (highs != 1024) $display("FAIL const_dwell_ch%0d: %0d high clocks want 1024", ch, highs); else passes++;
      end
   endtask
   task automatic test_chase;
      for (int c = 0; c < 8; c++) run_dwell(c, (c + 1) % 8, -1, 1'b0);
   endtask
   task automatic test_const_duty;
      const_mode = 1'b1;
      run_dwell(0, 1, -1, 1'b0);
      run_dwell(1, 2, -1, 1'b0);
      run_dwell(2, 3, -1, 1'b0);
      const_mode = 1'b0;
   endtask
   task automatic test_direction;
      run_dwell(3, 2, 2000, 1'b1);
      run_dwell(2, 1, -1, 1'b1);
      run_dwell(1, 0, -1, 1'b1);
      run_dwell(0, 7, -1, 1'b1);
      run_dwell(7, 6, -1, 1'b1);
      run_dwell(6, 5, -1, 1'b1);
   endtask
   task automatic test_enable_drop;
      int n;
      repeat (1000) @(negedge sysclk);
      enable_sw = 1'b0;
      repeat (3) @(negedge sysclk);
      checks++; if (pulse !== 8'h00) $display("FAIL drop_pulse: got %h want 00", pulse); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else passes++;
      checks++; if (active_ch !== 3'd5) $display("FAIL drop_hold_ch: got %0d want 5", active_ch); else passes++;
      checks++; if (lut_index !== 6'd0) $display("FAIL drop_index: got %0d want 0", lut_index); else passes++;
      repeat (5) @(negedge sysclk);
      enable_sw = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 8) begin @(negedge sysclk); n++; end
      checks++; if (busy !== 1'b1) $display("FAIL reenable_busy: got %b want 1 within 8 clocks", busy); else passes++;
      checks++; if (active_ch !== 3'd5) $display("FAIL reenable_ch: got %0d want 5", active_ch); else passes++;
      checks++; if (lut_index !== 6'd0) $display("FAIL reenable_index: got %0d want 0", lut_index); else passes++;
      repeat (64) @(negedge sysclk);
      checks++; if (lut_index !== 6'd1) $display("FAIL reenable_step: got %0d want 1", lut_index); else passes++;
   endtask
`ifdef LED_BREATH_ALL_EN
   task automatic test_all_mode;
      int n, bad, highs;
      all_sw = 1'b1;
      n = 0;
      while (active_ch == 3'd5 && n < 5000) begin @(negedge sysclk); n++; end
      checks++; if (active_ch !== 3'd4) $display("FAIL all_advance: got %0d want 4", active_ch); else passes++;
      checks++; if (busy !== 1'b1 || lut_index !== 6'd0) $display("FAIL all_no_gap: busy %b index %0d want 1/0", busy, lut_index); else passes++;
      bad = 0; highs = 0;
      for (int j = 0; j < 4096; j++) begin
         if (pulse !== 8'h00 && pulse !== 8'hFF) bad++;
         if (pulse === 8'hFF) highs++;
         if (int'(active_ch) != 4) bad++;
         if (j == 2000) all_sw = 1'b0;
         @(negedge sysclk);
      end
      checks++; if (bad != 0) $display("FAIL all_identical: %0d bad cycles want 0", bad); else passes++;
      checks++; if (highs == 0) $display("FAIL all_activity: pulses never high"); else passes++;
      bad = 0;
      for (int j = 0; j < 256; j++) begin
         if (pulse !== 8'h00 || active_ch !== 3'd4) bad++;
         @(negedge sysclk);
      end
      checks++; if (bad != 0) $display("FAIL resume_gap: %0d bad cycles want 0", bad); else passes++;
      checks++; if (active_ch !== 3'd3) $display("FAIL resume_ch: got %0d want 3", active_ch); else passes++;
      bad = 0;
      for (int j = 0; j < 640; j++) begin
         if ((pulse & 8'hF7) !== 8'h00) bad++;
         @(negedge sysclk);
      end
      checks++; if (bad != 0) $display("FAIL resume_single: %0d bad cycles want 0", bad); else passes++;
   endtask
`endif
   initial begin
      for (int i = 0; i < 64; i++)
         sine[i] = 6'(int'($floor(31.5 + 31.5 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5)));
      test_reset;
      test_chase;
      test_const_duty;
      test_direction;
      test_enable_drop;
`ifdef LED_BREATH_ALL_EN
      test_all_mode;
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
